// File: rtl/nv_nvdla_cdma_img_fifo_rd_pkg.sv
// Shared definitions for the CDMA image descriptor FIFO read side:
// descriptor layout, widths and controller state encoding.
package nv_nvdla_cdma_img_fifo_rd_pkg;

  localparam int DW      = 11;
  localparam int LEN_W   = 4;
  localparam int IDX_W   = 6;
  localparam int LINE_W  = 13;

  localparam int EOL_BIT = 10;
  localparam int LEN_LSB = 6;
  localparam int IDX_LSB = 0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    EXPAND = 2'd2
  } rd_state_e;

  typedef struct packed {
    logic             eol;
    logic [LEN_W-1:0] len_m1;
    logic [IDX_W-1:0] idx;
  } desc_t;

  function automatic desc_t unpack_desc(input logic [DW-1:0] raw);
    desc_t d;
    d.eol    = raw[EOL_BIT];
    d.len_m1 = raw[LEN_LSB +: LEN_W];
    d.idx    = raw[IDX_LSB +: IDX_W];
    return d;
  endfunction

endpackage

// File: rtl/nv_nvdla_cdma_img_fifo_rd_if.sv
// Descriptor-pop and element-beat handshakes between the read controller
// (master) and the FIFO / image packer side (slave).
interface nv_nvdla_cdma_img_fifo_rd_if;
  import nv_nvdla_cdma_img_fifo_rd_pkg::*;

  logic             fifo_rd_req;
  logic             fifo_rd_ready;
  logic [DW-1:0]    fifo_rd_data;
  logic             dat_pvld;
  logic             dat_prdy;
  logic [IDX_W-1:0] dat_idx;
  logic             dat_eol;
  logic             dat_eos;

  modport master (
    input  fifo_rd_req, fifo_rd_data, dat_prdy,
    output fifo_rd_ready, dat_pvld, dat_idx, dat_eol, dat_eos
  );

  modport slave (
    output fifo_rd_req, fifo_rd_data, dat_prdy,
    input  fifo_rd_ready, dat_pvld, dat_idx, dat_eol, dat_eos
  );
endinterface

// File: rtl/nv_nvdla_cdma_img_fifo_rd.sv
// Pops image descriptors from the CDMA FIFO and expands each into 1..16
// element beats, tracking end-of-line beats to detect surface completion.
module nv_nvdla_cdma_img_fifo_rd
  import nv_nvdla_cdma_img_fifo_rd_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset_,
  input  logic                       op_en,
  input  logic [LINE_W-1:0]          cfg_line_num,
  nv_nvdla_cdma_img_fifo_rd_if.master rd_if,
  output logic                       op_done,
  output logic                       busy
);

  localparam logic [LINE_W-1:0] LINE_ONE = {{(LINE_W-1){1'b0}}, 1'b1};
  localparam logic [LEN_W-1:0]  REM_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};
  localparam logic [IDX_W-1:0]  IDX_ONE  = {{(IDX_W-1){1'b0}}, 1'b1};

  rd_state_e         state_r;
  rd_state_e         state_nxt_s;
  logic [IDX_W-1:0]  idx_r;
  logic [LEN_W-1:0]  rem_r;
  logic              desc_eol_r;
  logic [LINE_W-1:0] line_cnt_r;
  logic [LINE_W-1:0] line_num_r;
  logic              pvld_r;
  logic              eol_r;
  logic              eos_r;
  logic              op_done_r;
  logic              busy_r;

  desc_t             desc_s;
  logic              beat_acc_s;
  logic              final_beat_s;
  logic              surf_end_s;
  logic              rd_ready_s;
  logic              pop_s;
  logic [LINE_W-1:0] line_cnt_nxt_s;

  assign desc_s = unpack_desc(rd_if.fifo_rd_data);

  // Beat/pop qualifiers; ready looks ahead on the final beat so bursts chain without bubbles
  always_comb begin
    final_beat_s = (state_r == EXPAND) && (rem_r == {LEN_W{1'b0}});
    beat_acc_s   = pvld_r && rd_if.dat_prdy;
    surf_end_s   = final_beat_s && desc_eol_r && (line_cnt_r == line_num_r);
    if (state_r == FETCH) begin
      rd_ready_s = 1'b1;
    end else if (final_beat_s && rd_if.dat_prdy && !surf_end_s) begin
      rd_ready_s = 1'b1;
    end else begin
      rd_ready_s = 1'b0;
    end
    pop_s = rd_ready_s && rd_if.fifo_rd_req;
    if (beat_acc_s && final_beat_s && desc_eol_r) begin
      line_cnt_nxt_s = line_cnt_r + LINE_ONE;
    end else begin
      line_cnt_nxt_s = line_cnt_r;
    end
  end

  // Next-state selection
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (op_en) begin
          state_nxt_s = FETCH;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      FETCH: begin
        if (pop_s) begin
          state_nxt_s = EXPAND;
        end else begin
          state_nxt_s = FETCH;
        end
      end
      EXPAND: begin
        if (beat_acc_s && surf_end_s) begin
          state_nxt_s = IDLE;
        end else if (beat_acc_s && final_beat_s && !pop_s) begin
          state_nxt_s = FETCH;
        end else begin
          state_nxt_s = EXPAND;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State, line tracking and registered beat outputs
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state_r    <= IDLE;
      idx_r      <= {IDX_W{1'b0}};
      rem_r      <= {LEN_W{1'b0}};
      desc_eol_r <= 1'b0;
      line_cnt_r <= {LINE_W{1'b0}};
      line_num_r <= {LINE_W{1'b0}};
      pvld_r     <= 1'b0;
      eol_r      <= 1'b0;
      eos_r      <= 1'b0;
      op_done_r  <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      busy_r    <= (state_nxt_s != IDLE);
      op_done_r <= beat_acc_s && surf_end_s;
      if ((state_r == IDLE) && op_en) begin
        line_num_r <= cfg_line_num;
        line_cnt_r <= {LINE_W{1'b0}};
      end else begin
        line_cnt_r <= line_cnt_nxt_s;
      end
      // A new descriptor's eos must see the line count including the line just closed
      if (pop_s) begin
        idx_r      <= desc_s.idx;
        rem_r      <= desc_s.len_m1;
        desc_eol_r <= desc_s.eol;
        pvld_r     <= 1'b1;
        eol_r      <= desc_s.eol && (desc_s.len_m1 == {LEN_W{1'b0}});
        eos_r      <= desc_s.eol && (desc_s.len_m1 == {LEN_W{1'b0}})
                      && (line_cnt_nxt_s == line_num_r);
      end else if (beat_acc_s && !final_beat_s) begin
        idx_r <= idx_r + IDX_ONE;
        rem_r <= rem_r - REM_ONE;
        eol_r <= desc_eol_r && (rem_r == REM_ONE);
        eos_r <= desc_eol_r && (rem_r == REM_ONE) && (line_cnt_r == line_num_r);
      end else if (beat_acc_s) begin
        pvld_r <= 1'b0;
        eol_r  <= 1'b0;
        eos_r  <= 1'b0;
      end else begin
        pvld_r <= pvld_r;
      end
    end
  end

  assign rd_if.fifo_rd_ready = rd_ready_s;
  assign rd_if.dat_pvld      = pvld_r;
  assign rd_if.dat_idx       = idx_r;
  assign rd_if.dat_eol       = eol_r;
  assign rd_if.dat_eos       = eos_r;
  assign op_done             = op_done_r;
  assign busy                = busy_r;

endmodule
